npu_cmd_sequencer: RTL and testbench
====================================

Name: npu_cmd_sequencer

Overview:
- Host-side initiator for the NPU core interface: the other end of the `inst` / `mem_in` / `out` bus.
- Accepts high-level commands from a host: load K, load Q, run, read results.
- Expands each command into a cycle-accurate stream of 20-bit instruction words with streamed activation/weight data.
- Drains the core's partial-sum output back to the host over a valid/ready port.
- Sits between the host/testbench and the core's top-level instance.

Parameters:
- col, 8, number of output columns (psum lanes)
- bw, 8, activation/weight bit width
- bw_psum, 2*bw+4, partial-sum bit width per column
- pr, 8, parallel input lanes per mem_in word
- mac_lat, 4, idle cycles after the last MAC instruction before the run is complete
- rd_lat, 2, cycles from an OFIFO_RD instruction to valid core_out

Ports:
- clk  input  1  clock, all logic on the rising edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered by host
- cmd_ready  output  1  sequencer idle and accepting a command
- cmd_op  input  2  0=LOAD_K, 1=LOAD_Q, 2=RUN, 3=READ
- cmd_len  input  4  beat count minus one (1..16 beats)
- din_valid  input  1  load data beat offered
- din_ready  output  1  load beat accepted this cycle
- din  input  pr*bw  load data beat
- inst  output  20  instruction word to the core
- mem_in  output  pr*bw  data word to the core
- core_out  input  bw_psum*col  core result bus
- rd_valid  output  1  result word available
- rd_ready  input  1  host accepts result word
- rd_data  output  bw_psum*col  captured result word
- busy  output  1  high in any non-IDLE state
- done  output  1  one-cycle pulse when a command completes

Behaviour:
- Instruction field layout (fixed):
  - inst[19:16] opcode: 0 NOP, 1 KMEM_WR, 2 QMEM_WR, 3 MAC, 4 OFIFO_RD
  - inst[15:4] zero
  - inst[3:0] address
- inst, mem_in, rd_data, rd_valid and done are registered.
- Reset values: inst=0 (NOP), mem_in=0, rd_valid=0, rd_data=0, done=0, busy=0, cmd_ready=1, state=IDLE, counters=0.
- States: IDLE, LOAD, RUN, DRAIN, RD_ISSUE, RD_WAIT, RD_HOLD.
- IDLE:
  - cmd_ready=1; inst=NOP.
  - On cmd_valid, latch op and len=cmd_len+1, clear cnt.
  - Next state: LOAD for ops 0/1, RUN for op 2, RD_ISSUE for op 3.
- LOAD:
  - din_ready=1.
  - On each beat (din_valid & din_ready): next cycle inst={KMEM_WR or QMEM_WR, addr=cnt}, mem_in=din, cnt++.
  - Cycles with din_valid=0: inst=NOP, mem_in holds, cnt holds.
  - After beat len: assert done for one cycle and return to IDLE.
  - din_ready=0 in every other state.
- RUN:
  - Issues len consecutive MAC instructions, addr=0..len-1, one per cycle, with no gaps; mem_in=0.
  - Then goes to DRAIN.
- DRAIN:
  - inst=NOP for mac_lat cycles (separate latency counter).
  - Then done pulse and IDLE.
- RD_ISSUE:
  - Issues one OFIFO_RD (addr=cnt) for one cycle, then RD_WAIT.
- RD_WAIT:
  - NOP for rd_lat cycles.
  - Then capture core_out into rd_data, set rd_valid=1, go to RD_HOLD.
- RD_HOLD:
  - rd_data stable while rd_valid & !rd_ready.
  - On rd_ready: rd_valid=0, cnt++.
  - If cnt==len: done and IDLE; otherwise RD_ISSUE.
  - A new OFIFO_RD is never issued while a captured word is unconsumed.
- Edge cases:
  - cmd_valid while busy is ignored; cmd_ready=0, nothing is latched.
  - cmd_len=15 gives 16 beats; addr wraps are never reached (max addr 15).
  - done and cmd_ready are never high in the same cycle; IDLE is entered one cycle after done.
- Reset asserted mid-command:
  - Immediately forces the reset values.
  - A partial load or read is abandoned; no done pulse is generated.

Decomposition:
- Shared package npu_pkg holds:
  - opcode localparams (OP_NOP..OP_OFIFO_RD)
  - cmd_op encodings
  - instruction field positions
  - state enumeration
- One sub-module is natural: npu_rd_capture, which holds the rd_lat delay counter and the rd_data/rd_valid hold register with its handshake.

Test Plan:
- LOAD_K, cmd_len=3, din_valid held high with din=0x01..0x04 -> inst = 0x10000, 0x10001, 0x10002, 0x10003 on four consecutive cycles, mem_in matching din, then done pulse.
- LOAD_Q, cmd_len=1, din_valid low for 2 cycles between beats -> inst NOP during the gap, addrs 0 and 1, one done pulse.
- RUN, cmd_len=2, mac_lat=4 -> inst 0x30000, 0x30001, 0x30002, then 4 NOPs; done in the 8th cycle after the RUN state is entered.
- READ, cmd_len=1, rd_ready held low 5 cycles on the first word -> exactly one OFIFO_RD outstanding, rd_data stable for all 5 cycles, second OFIFO_RD issued only after the handshake.
- cmd_valid asserted during RUN -> cmd_ready=0, the command is not latched, and the instruction stream is unchanged.
- reset pulsed low in the middle of LOAD -> inst=0, busy=0, cmd_ready=1 while reset is low, no done pulse; a new LOAD afterwards restarts at addr 0.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared encodings for the NPU command sequencer: opcodes, host command ops,
// instruction field positions and the sequencer state set.
package npu_pkg;

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_KMEM_WR  = 4'd1;
  localparam logic [3:0] OP_QMEM_WR  = 4'd2;
  localparam logic [3:0] OP_MAC      = 4'd3;
  localparam logic [3:0] OP_OFIFO_RD = 4'd4;

  localparam logic [1:0] CMD_LOAD_K = 2'd0;
  localparam logic [1:0] CMD_LOAD_Q = 2'd1;
  localparam logic [1:0] CMD_RUN    = 2'd2;
  localparam logic [1:0] CMD_READ   = 2'd3;

  localparam int INST_W   = 20;
  localparam int OPC_MSB  = 19;
  localparam int OPC_LSB  = 16;
  localparam int ADDR_MSB = 3;
  localparam int ADDR_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_HOLD
  } state_t;

  // Bits between the opcode and address fields are always zero.
  function automatic logic [INST_W-1:0] mk_inst(input logic [3:0] opc, input logic [3:0] addr);
    logic [INST_W-1:0] w;
    w = '0;
    w[OPC_MSB:OPC_LSB]   = opc;
    w[ADDR_MSB:ADDR_LSB] = addr;
    return w;
  endfunction

endpackage

// File: rtl/npu_rd_capture.sv
// Result capture for READ: waits rd_lat cycles after an OFIFO_RD issue, grabs
// core_out and holds it under a valid/ready handshake until the host takes it.
module npu_rd_capture
  import npu_pkg::*;
#(
  parameter int w      = 160,
  parameter int rd_lat = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [w-1:0] core_out,
  input  logic         rd_ready,
  output logic         cap,
  output logic         rd_valid,
  output logic [w-1:0] rd_data
);

  localparam int LW = $clog2(rd_lat + 2);

  logic          waiting;
  logic [LW-1:0] lat;

  // start marks the cycle the OFIFO_RD is registered; core_out is valid rd_lat cycles after it appears.
  assign cap = waiting && (lat == LW'(rd_lat));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waiting  <= 1'b0;
      lat      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (start) begin
        waiting <= 1'b1;
        lat     <= '0;
      end else if (cap) begin
        waiting  <= 1'b0;
        rd_data  <= core_out;
        rd_valid <= 1'b1;
      end else if (waiting) begin
        lat <= lat + 1'b1;
      end
      if (rd_valid && rd_ready)
        rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/npu_cmd_sequencer.sv
// Host-side command sequencer: expands LOAD/RUN/READ commands into the core's
// instruction/data stream and returns captured partial sums to the host.
module npu_cmd_sequencer
  import npu_pkg::*;
#(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int pr      = 8,
  parameter int mac_lat = 4,
  parameter int rd_lat  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [3:0]             cmd_len,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [pr*bw-1:0]       din,
  output logic [INST_W-1:0]      inst,
  output logic [pr*bw-1:0]       mem_in,
  input  logic [bw_psum*col-1:0] core_out,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [bw_psum*col-1:0] rd_data,
  output logic                   busy,
  output logic                   done
);

  localparam int LATW = $clog2(mac_lat + 2);

  state_t          state;
  logic [1:0]      op;
  logic [4:0]      len;
  logic [4:0]      cnt;
  logic [LATW-1:0] lat;
  logic            cap;
  logic            rd_start;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  // done is raised on the final beat itself, so no further beat may be taken.
  assign din_ready = (state == S_LOAD) && !done;
  assign rd_start  = (state == S_RD_ISSUE);

  npu_rd_capture #(.w(bw_psum*col), .rd_lat(rd_lat)) u_cap (
    .clk      (clk),
    .reset    (reset),
    .start    (rd_start),
    .core_out (core_out),
    .rd_ready (rd_ready),
    .cap      (cap),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      op     <= CMD_LOAD_K;
      len    <= '0;
      cnt    <= '0;
      lat    <= '0;
      inst   <= mk_inst(OP_NOP, 4'd0);
      mem_in <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      inst <= mk_inst(OP_NOP, 4'd0);
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op  <= cmd_op;
            len <= {1'b0, cmd_len} + 5'd1;
            cnt <= '0;
            lat <= '0;
            case (cmd_op)
              CMD_LOAD_K, CMD_LOAD_Q: state <= S_LOAD;
              CMD_RUN:                state <= S_RUN;
              default:                state <= S_RD_ISSUE;
            endcase
          end
        end
        S_LOAD: begin
          if (done) begin
            state <= S_IDLE;
          end else if (din_valid) begin
            inst   <= mk_inst((op == CMD_LOAD_K) ? OP_KMEM_WR : OP_QMEM_WR, cnt[3:0]);
            mem_in <= din;
            cnt    <= cnt + 5'd1;
            done   <= (cnt + 5'd1 == len);
          end
        end
        S_RUN: begin
          inst   <= mk_inst(OP_MAC, cnt[3:0]);
          mem_in <= '0;
          cnt    <= cnt + 5'd1;
          if (cnt + 5'd1 == len) begin
            state <= S_DRAIN;
            lat   <= '0;
          end
        end
        S_DRAIN: begin
          if (done)
            state <= S_IDLE;
          else if (lat == LATW'(mac_lat - 1))
            done <= 1'b1;
          else
            lat <= lat + 1'b1;
        end
        S_RD_ISSUE: begin
          inst  <= mk_inst(OP_OFIFO_RD, cnt[3:0]);
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (cap)
            state <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (done) begin
            state <= S_IDLE;
          end else if (rd_valid && rd_ready) begin
            cnt <= cnt + 5'd1;
            if (cnt + 5'd1 == len)
              done <= 1'b1;
            else
              state <= S_RD_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_cmd_sequencer.sv
// Directed bench for npu_cmd_sequencer: each command's instruction stream,
// handshakes and done timing checked cycle by cycle against hand-derived values.
module tb_npu_cmd_sequencer;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [3:0]   cmd_len;
  logic         din_valid;
  logic         din_ready;
  logic [63:0]  din;
  logic [19:0]  inst;
  logic [63:0]  mem_in;
  logic [159:0] core_out;
  logic         rd_valid;
  logic         rd_ready;
  logic [159:0] rd_data;
  logic         busy;
  logic         done;

  int n_chk;
  int n_err;
  int n_done;

  npu_cmd_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .inst      (inst),
    .mem_in    (mem_in),
    .core_out  (core_out),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) n_done++;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  localparam logic [159:0] WORD_A = {8{20'hA1B2C}};
  localparam logic [159:0] WORD_B = {8{20'h5F00D}};
  localparam logic [159:0] WORD_C = {8{20'h0C0DE}};

  initial begin
    n_chk = 0; n_err = 0; n_done = 0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 4'd0;
    din_valid = 1'b0; din = '0; core_out = '0; rd_ready = 1'b0;
    tick(); tick();
    chk("rst_inst", inst, 20'h0);
    chk("rst_mem_in", mem_in, 64'h0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 160'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_din_ready", din_ready, 1'b0);
    reset = 1'b1;
    tick();

    // LOAD_K, 4 back-to-back beats
    issue(2'd0, 4'd3);
    chk("lk_busy", busy, 1'b1);
    chk("lk_cmd_ready", cmd_ready, 1'b0);
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 64'(i + 1);
      chk("lk_din_ready", din_ready, 1'b1);
      tick();
      chk("lk_inst", inst, 20'h10000 + 20'(i));
      chk("lk_mem_in", mem_in, 64'(i + 1));
      chk("lk_done", done, i == 3);
    end
    chk("lk_din_ready_end", din_ready, 1'b0);
    din_valid = 1'b0;
    tick();
    chk("lk_idle_done", done, 1'b0);
    chk("lk_idle_ready", cmd_ready, 1'b1);
    chk("lk_idle_inst", inst, 20'h0);

    // LOAD_Q, 2 beats with a 2-cycle gap
    issue(2'd1, 4'd1);
    din_valid = 1'b1; din = 64'hAA;
    tick();
    chk("lq_inst0", inst, 20'h20000);
    chk("lq_mem0", mem_in, 64'hAA);
    din_valid = 1'b0; din = 64'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lq_gap_inst", inst, 20'h0);
      chk("lq_gap_mem", mem_in, 64'hAA);
      chk("lq_gap_done", done, 1'b0);
    end
    din_valid = 1'b1; din = 64'hBB;
    tick();
    chk("lq_inst1", inst, 20'h20001);
    chk("lq_mem1", mem_in, 64'hBB);
    chk("lq_done", done, 1'b1);
    din_valid = 1'b0;
    tick();
    chk("lq_done_clr", done, 1'b0);
    chk("lq_ready", cmd_ready, 1'b1);

    // RUN, 3 MACs then drain; a READ offered mid-run must be ignored
    issue(2'd2, 4'd2);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = 4'd0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk("run_inst", inst, (c <= 4) ? 20'h30000 + 20'(c - 2) : 20'h0);
      chk("run_done", done, c == 8);
      chk("run_cmd_ready", cmd_ready, 1'b0);
      if (c <= 4) chk("run_mem_in", mem_in, 64'h0);
    end
    cmd_valid = 1'b0;
    tick();
    chk("run_idle_busy", busy, 1'b0);
    chk("run_idle_done", done, 1'b0);
    chk("run_idle_inst", inst, 20'h0);
    tick();
    chk("run_no_latch", busy, 1'b0);

    // READ, 2 words, first held 5 cycles by the host
    core_out = WORD_A;
    issue(2'd3, 4'd1);
    tick();
    chk("rd_issue0", inst, 20'h40000);
    tick();
    chk("rd_wait_inst", inst, 20'h0);
    chk("rd_wait_valid", rd_valid, 1'b0);
    tick();
    chk("rd_wait_valid2", rd_valid, 1'b0);
    tick();
    chk("rd_valid0", rd_valid, 1'b1);
    chk("rd_data0", rd_data, WORD_A);
    core_out = WORD_B;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_hold_valid", rd_valid, 1'b1);
      chk("rd_hold_data", rd_data, WORD_A);
      chk("rd_hold_inst", inst, 20'h0);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("rd_hs_valid", rd_valid, 1'b0);
    chk("rd_hs_inst", inst, 20'h0);
    chk("rd_hs_done", done, 1'b0);
    core_out = WORD_C;
    tick();
    chk("rd_issue1", inst, 20'h40001);
    tick(); tick();
    chk("rd_wait1_valid", rd_valid, 1'b0);
    tick();
    chk("rd_valid1", rd_valid, 1'b1);
    chk("rd_data1", rd_data, WORD_C);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("rd_done", done, 1'b1);
    chk("rd_done_ready", cmd_ready, 1'b0);
    tick();
    chk("rd_idle_done", done, 1'b0);
    chk("rd_idle_ready", cmd_ready, 1'b1);

    // LOAD_Q, maximum length of 16 beats
    issue(2'd1, 4'd15);
    din_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 64'(i + 8'h30);
      tick();
      chk("lmax_inst", inst, 20'h20000 + 20'(i));
      chk("lmax_done", done, i == 15);
    end
    din_valid = 1'b0;
    tick();
    chk("lmax_ready", cmd_ready, 1'b1);

    // Reset in the middle of a LOAD_K: abandoned, then a fresh load restarts at addr 0
    issue(2'd0, 4'd3);
    din_valid = 1'b1;
    din = 64'h11; tick();
    din = 64'h22; tick();
    chk("mid_inst", inst, 20'h10001);
    #2 reset = 1'b0;
    #1;
    chk("mr_inst", inst, 20'h0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_ready", cmd_ready, 1'b1);
    chk("mr_done", done, 1'b0);
    tick();
    chk("mr_hold_inst", inst, 20'h0);
    chk("mr_hold_busy", busy, 1'b0);
    din_valid = 1'b0;
    reset = 1'b1;
    tick();
    issue(2'd0, 4'd0);
    din_valid = 1'b1; din = 64'h55;
    tick();
    din_valid = 1'b0;
    chk("ar_inst", inst, 20'h10000);
    chk("ar_mem", mem_in, 64'h55);
    chk("ar_done", done, 1'b1);
    tick();
    chk("ar_ready", cmd_ready, 1'b1);
    chk("done_count", 160'(n_done), 160'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
